// File: rtl/dataproc_ingress.sv
// CPU-writable byte FIFO feeding the dataproc stream, with DATA/STATUS/CTRL registers.
// Optional TXCNT popped-byte counter at +0xC is built when DATAPROC_INGRESS_TXCNT_EN is defined.
module dataproc_ingress #(
    parameter int unsigned DEPTH     = 16,
    parameter logic [31:0] ADDR_BASE = 32'h0300_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        iomem_valid,
    output logic        iomem_ready,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic [31:0] iomem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    localparam logic [1:0] SEL_DATA   = 2'd0;
    localparam logic [1:0] SEL_STATUS = 2'd1;
    localparam logic [1:0] SEL_CTRL   = 2'd2;
    localparam logic [1:0] SEL_TXCNT  = 2'd3;

    typedef enum logic {
        BUS_IDLE,
        BUS_ACK
    } bus_state_t;

    bus_state_t state;
    bus_state_t state_next;

    logic          hit;
    logic          ack;
    logic          req_write;
    logic          req_strb0;
    logic [1:0]    req_sel;
    logic [7:0]    req_wdata;
    logic [31:0]   rd_word;
    logic [31:0]   status_word;
    logic [8:0]    count9;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [CW-1:0] count;
    logic          overflow;
    logic          enable;

    logic          wr_ack;
    logic          push_req;
    logic          ctrl_wr;
    logic          flush;
    logic          ovf_clr;
    logic          full;
    logic          empty;
    logic          pop;
    logic          push;
    logic          drop;
    logic          unused_bits;

    assign hit         = iomem_addr[31:4] == ADDR_BASE[31:4];
    assign unused_bits = ^{iomem_addr[1:0], iomem_wdata[31:8]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= BUS_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // An acknowledge always returns to IDLE, which guarantees a ready-low cycle between acks.
    always_comb begin
        state_next = state;
        case (state)
            BUS_IDLE: if (iomem_valid && hit) state_next = BUS_ACK;
            BUS_ACK:  state_next = BUS_IDLE;
            default:  state_next = BUS_IDLE;
        endcase
    end

    always_comb begin
        ack         = (state == BUS_ACK);
        iomem_ready = ack;
        iomem_rdata = (ack && !req_write) ? rd_word : '0;
    end

    always_ff @(posedge clk) begin
        if (state == BUS_IDLE && iomem_valid && hit) begin
            req_write <= |iomem_wstrb;
            req_strb0 <= iomem_wstrb[0];
            req_sel   <= iomem_addr[3:2];
            req_wdata <= iomem_wdata[7:0];
        end
    end

    assign wr_ack   = ack && req_write;
    assign push_req = wr_ack && (req_sel == SEL_DATA) && req_strb0;
    assign ctrl_wr  = wr_ack && (req_sel == SEL_CTRL) && req_strb0;
    assign flush    = ctrl_wr && req_wdata[1];
    assign ovf_clr  = ctrl_wr && req_wdata[2];

    assign empty     = (count == '0);
    assign full      = (count == CW'(DEPTH));
    assign out_valid = enable && !empty;
    assign out_data  = mem[rptr];
    assign pop       = out_valid && out_ready;
    assign push      = push_req && (!full || pop);
    assign drop      = push_req && full && !pop;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= req_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
            enable   <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                enable <= req_wdata[0];
            end
            if (ovf_clr) begin
                overflow <= 1'b0;
            end else if (drop) begin
                overflow <= 1'b1;
            end
            // A pop in the flush cycle still completes on the stream side; the flush wins on state.
            if (flush) begin
                wptr  <= '0;
                rptr  <= '0;
                count <= '0;
            end else begin
                if (push) wptr <= wptr + AW'(1);
                if (pop)  rptr <= rptr + AW'(1);
                case ({push, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
        end
    end

`ifdef DATAPROC_INGRESS_TXCNT_EN
    logic [31:0] txcnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            txcnt <= '0;
        end else if (wr_ack && req_sel == SEL_TXCNT) begin
            txcnt <= '0;
        end else if (pop) begin
            txcnt <= txcnt + 32'd1;
        end
    end
`endif

    always_comb begin
        count9          = 9'(count);
        status_word     = '0;
        status_word[0]  = empty;
        status_word[1]  = full;
        status_word[2]  = overflow;
        status_word[15:8] = count9[7:0];
    end

    always_comb begin
        rd_word = '0;
        case (req_sel)
            SEL_DATA:   rd_word = '0;
            SEL_STATUS: rd_word = status_word;
            SEL_CTRL:   rd_word = {31'd0, enable};
`ifdef DATAPROC_INGRESS_TXCNT_EN
            SEL_TXCNT:  rd_word = txcnt;
`else
            SEL_TXCNT:  rd_word = '0;
`endif
            default:    rd_word = '0;
        endcase
    end

endmodule

// File: tb/tb_dataproc_ingress.sv
// Self-checking bench for dataproc_ingress: bus tasks drive registers, a scoreboard queue checks the stream.
module tb_dataproc_ingress;

    localparam logic [31:0] BASE   = 32'h0300_0000;
    localparam logic [31:0] A_DATA = BASE + 32'h0;
    localparam logic [31:0] A_STAT = BASE + 32'h4;
    localparam logic [31:0] A_CTRL = BASE + 32'h8;
    localparam logic [31:0] A_TX   = BASE + 32'hC;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        iomem_valid = 1'b0;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb = '0;
    logic [31:0] iomem_addr = '0;
    logic [31:0] iomem_wdata = '0;
    logic [31:0] iomem_rdata;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_data;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    logic [7:0]  exp_q[$];
    logic        ack_out_valid = 1'b0;

    dataproc_ingress #(
        .DEPTH(16),
        .ADDR_BASE(BASE)
    ) dut (
        .clk(clk),
        .reset(reset),
        .iomem_valid(iomem_valid),
        .iomem_ready(iomem_ready),
        .iomem_wstrb(iomem_wstrb),
        .iomem_addr(iomem_addr),
        .iomem_wdata(iomem_wdata),
        .iomem_rdata(iomem_rdata),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data)
    );

    always #5 clk = ~clk;

    // Stream scoreboard: sampled mid-cycle, so the values seen are those in force at the next rising edge.
    always @(negedge clk) begin
        logic [7:0] exp_b;
        if (!reset && out_valid === 1'b1 && out_ready === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL pop_unexpected: got %02h, required no byte", out_data);
            end else begin
                exp_b = exp_q.pop_front();
                if (out_data !== exp_b) begin
                    miscompares++;
                    $display("FAIL pop_data: got %02h, required %02h", out_data, exp_b);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic bus_xfer(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                            input bit expect_ack, input bit pulse_ready, output logic [31:0] r);
        bit ok;
        ok = 1'b0;
        r  = '0;
        @(posedge clk); #1;
        iomem_valid = 1'b1;
        iomem_addr  = a;
        iomem_wstrb = s;
        iomem_wdata = d;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (iomem_ready === 1'b1) begin
                ok = 1'b1;
                r = iomem_rdata;
                ack_out_valid = out_valid;
                if (pulse_ready) out_ready = 1'b1;
                break;
            end
        end
        if (ok) begin
            @(posedge clk); #1;
            vectors++;
            if (iomem_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL ack_width addr=%08h: ready=%b one cycle after ack, required 0", a, iomem_ready);
            end
        end
        iomem_valid = 1'b0;
        iomem_wstrb = '0;
        if (pulse_ready) out_ready = 1'b0;
        vectors++;
        if (ok !== expect_ack) begin
            miscompares++;
            $display("FAIL bus_ack addr=%08h: acknowledged=%0d, required %0d", a, ok, expect_ack);
        end
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] dummy;
        bus_xfer(a, 4'hF, d, 1'b1, 1'b0, dummy);
    endtask

    task automatic bus_rd(input logic [31:0] a, output logic [31:0] r);
        bus_xfer(a, 4'h0, '0, 1'b1, 1'b0, r);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk); #1;
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s_drain: %0d bytes still expected, required 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        reset = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (iomem_ready !== 1'b0 || iomem_rdata !== 32'h0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: ready=%b rdata=%08h out_valid=%b, required 0/0/0",
                     iomem_ready, iomem_rdata, out_valid);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (iomem_ready !== 1'b0 || iomem_rdata !== 32'h0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset_outputs: ready=%b rdata=%08h out_valid=%b, required 0/0/0",
                     iomem_ready, iomem_rdata, out_valid);
        end
        bus_rd(A_STAT, rd);
        vectors++;
        if (rd !== 32'h0000_0001) begin
            miscompares++;
            $display("FAIL reset_status: got %08h, required 00000001", rd);
        end
        bus_rd(A_CTRL, rd);
        vectors++;
        if (rd !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %08h, required 00000000", rd);
        end
        bus_rd(A_TX, rd);
        vectors++;
        if (rd !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_txcnt: got %08h, required 00000000", rd);
        end
    endtask

    task automatic test_stream();
        logic [31:0] rd;
        out_ready = 1'b1;
        bus_wr(A_CTRL, 32'h1);
        exp_q.push_back(8'h41);
        bus_wr(A_DATA, 32'h41);
        vectors++;
        if (ack_out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL push_bypass: out_valid=%b in push cycle, required 0", ack_out_valid);
        end
        exp_q.push_back(8'h42);
        bus_wr(A_DATA, 32'h42);
        exp_q.push_back(8'h43);
        bus_wr(A_DATA, 32'h43);
        wait_drain("stream");
        bus_rd(A_DATA, rd);
        vectors++;
        if (rd !== 32'h0) begin
            miscompares++;
            $display("FAIL data_read: got %08h, required 00000000", rd);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] rd;
        out_ready = 1'b0;
        bus_wr(A_CTRL, 32'h0);
        for (int i = 0; i < 17; i++) begin
            if (i < 16) exp_q.push_back(8'(8'h60 + i));
            bus_wr(A_DATA, 32'(8'h60 + i));
        end
        bus_rd(A_STAT, rd);
        vectors++;
        if (rd !== 32'h0000_1006) begin
            miscompares++;
            $display("FAIL overflow_status: got %08h, required 00001006", rd);
        end
        out_ready = 1'b1;
        bus_wr(A_CTRL, 32'h5);
        wait_drain("overflow");
        bus_rd(A_STAT, rd);
        vectors++;
        if (rd !== 32'h0000_0001) begin
            miscompares++;
            $display("FAIL overflow_clear_status: got %08h, required 00000001", rd);
        end
    endtask

    task automatic test_full_pop();
        logic [31:0] rd;
        out_ready = 1'b0;
        bus_wr(A_CTRL, 32'h1);
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(8'(8'h80 + i));
            bus_wr(A_DATA, 32'(8'h80 + i));
        end
        bus_rd(A_STAT, rd);
        vectors++;
        if (rd !== 32'h0000_1002) begin
            miscompares++;
            $display("FAIL full_status: got %08h, required 00001002", rd);
        end
        exp_q.push_back(8'h99);
        bus_xfer(A_DATA, 4'hF, 32'h99, 1'b1, 1'b1, rd);
        bus_rd(A_STAT, rd);
        vectors++;
        if (rd !== 32'h0000_1002) begin
            miscompares++;
            $display("FAIL full_pop_status: got %08h, required 00001002", rd);
        end
        out_ready = 1'b1;
        wait_drain("full_pop");
        bus_rd(A_STAT, rd);
        vectors++;
        if (rd !== 32'h0000_0001) begin
            miscompares++;
            $display("FAIL full_pop_empty: got %08h, required 00000001", rd);
        end
    endtask

    task automatic test_flush();
        logic [31:0] rd;
        out_ready = 1'b0;
        bus_wr(A_CTRL, 32'h1);
        for (int i = 0; i < 5; i++) bus_wr(A_DATA, 32'(8'hC0 + i));
        bus_wr(A_CTRL, 32'h2);
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_out_valid: got %b, required 0", out_valid);
        end
        bus_rd(A_STAT, rd);
        vectors++;
        if (rd !== 32'h0000_0001) begin
            miscompares++;
            $display("FAIL flush_status: got %08h, required 00000001", rd);
        end
        bus_rd(A_CTRL, rd);
        vectors++;
        if (rd !== 32'h0) begin
            miscompares++;
            $display("FAIL flush_ctrl: got %08h, required 00000000", rd);
        end
        out_ready = 1'b1;
        bus_wr(A_CTRL, 32'h1);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_stall_wrap();
        logic [31:0] rd;
        out_ready = 1'b0;
        bus_wr(A_CTRL, 32'h1);
        exp_q.push_back(8'hA5);
        bus_wr(A_DATA, 32'hA5);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            vectors++;
            if (out_valid !== 1'b1 || out_data !== 8'hA5) begin
                miscompares++;
                $display("FAIL stall_hold cycle %0d: valid=%b data=%02h, required 1/a5", i, out_valid, out_data);
            end
        end
        out_ready = 1'b1;
        wait_drain("stall");
        bus_wr(A_TX, 32'h0);
        for (int i = 0; i < 20; i++) begin
            exp_q.push_back(8'(8'hD0 + i));
            bus_wr(A_DATA, 32'(8'hD0 + i));
        end
        wait_drain("wrap");
        bus_rd(A_TX, rd);
        vectors++;
`ifdef DATAPROC_INGRESS_TXCNT_EN
        if (rd !== 32'd20) begin
            miscompares++;
            $display("FAIL txcnt: got %0d, required 20", rd);
        end
`else
        if (rd !== 32'd0) begin
            miscompares++;
            $display("FAIL txcnt: got %0d, required 0", rd);
        end
`endif
    endtask

    task automatic test_unmapped();
        logic [31:0] rd;
        out_ready = 1'b1;
        bus_xfer(BASE + 32'h10, 4'hF, 32'h55, 1'b0, 1'b0, rd);
        bus_xfer(BASE - 32'h4, 4'h0, '0, 1'b0, 1'b0, rd);
        bus_rd(A_STAT, rd);
        vectors++;
        if (rd !== 32'h0000_0001) begin
            miscompares++;
            $display("FAIL unmapped_status: got %08h, required 00000001", rd);
        end
    endtask

    task automatic test_reset_midstream();
        logic [31:0] rd;
        out_ready = 1'b0;
        bus_wr(A_CTRL, 32'h1);
        for (int i = 0; i < 3; i++) bus_wr(A_DATA, 32'(8'hE0 + i));
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.delete();
        vectors++;
        if (iomem_ready !== 1'b0 || iomem_rdata !== 32'h0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_outputs: ready=%b rdata=%08h out_valid=%b, required 0/0/0",
                     iomem_ready, iomem_rdata, out_valid);
        end
        bus_rd(A_STAT, rd);
        vectors++;
        if (rd !== 32'h0000_0001) begin
            miscompares++;
            $display("FAIL midreset_status: got %08h, required 00000001", rd);
        end
        bus_rd(A_CTRL, rd);
        vectors++;
        if (rd !== 32'h0) begin
            miscompares++;
            $display("FAIL midreset_ctrl: got %08h, required 00000000", rd);
        end
        // Request raised together with reset must never be acknowledged.
        @(posedge clk); #1;
        iomem_valid = 1'b1;
        iomem_addr  = A_STAT;
        iomem_wstrb = 4'h0;
        reset       = 1'b1;
        @(posedge clk); #1;
        reset       = 1'b0;
        iomem_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (iomem_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL abort_ack cycle %0d: ready=%b, required 0", i, iomem_ready);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_overflow();
        test_full_pop();
        test_flush();
        test_stall_wrap();
        test_unmapped();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
